// File: rtl/writeback_unit_if.sv
// Bus bundle for the writeback unit: decode issue, ALU and load result
// handshakes, the register-file write port, and scoreboard status.
interface writeback_unit_if #(
   parameter int XLEN = 32
);
   logic            issue_valid;
   logic [4:0]      issue_index;
   logic            alu_valid;
   logic [4:0]      alu_index;
   logic [XLEN-1:0] alu_value;
   logic            alu_ready;
   logic            mem_valid;
   logic [4:0]      mem_index;
   logic [XLEN-1:0] mem_value;
   logic            mem_ready;
   logic [4:0]      write_index;
   logic [XLEN-1:0] write_value;
   logic [31:0]     busy;
   logic            sb_error;

   // Driver side: decode and the execution units.
   modport master (
      output issue_valid, issue_index,
      output alu_valid, alu_index, alu_value,
      output mem_valid, mem_index, mem_value,
      input  alu_ready, mem_ready,
      input  write_index, write_value, busy, sb_error
   );

   // Writeback unit side.
   modport slave (
      input  issue_valid, issue_index,
      input  alu_valid, alu_index, alu_value,
      input  mem_valid, mem_index, mem_value,
      output alu_ready, mem_ready,
      output write_index, write_value, busy, sb_error
   );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates load and ALU results onto the single registered
// register-file write port (load > queued ALU > direct ALU), buffers ALU
// results that lose arbitration, and keeps the 32-entry busy scoreboard.
module writeback_unit #(
   parameter int FIFO_DEPTH = 4,
   parameter int XLEN       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   writeback_unit_if.slave   wb
);
   localparam int AW = $clog2(FIFO_DEPTH);

   // ALU holding FIFO; pointers carry one extra bit to tell full from empty.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [4:0]       r_fifo_idx [FIFO_DEPTH];
   logic [XLEN-1:0]  r_fifo_val [FIFO_DEPTH];

   logic [4:0]       r_write_index;
   logic [XLEN-1:0]  r_write_value;
   logic [31:0]      r_busy;
   logic             r_sb_error;

   logic             w_empty;
   logic             w_full;
   logic             w_alu_acc;
   logic             w_push;
   logic             w_pop;
   logic [4:0]       w_sel_index;
   logic [XLEN-1:0]  w_sel_value;
   logic [31:0]      w_set_mask;
   logic [31:0]      w_clr_mask;
   logic             w_issue_err;
   logic             w_mem_err;
   logic             w_alu_err;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Readiness comes from registered FIFO state only, so a pop in the same
   // cycle does not open a slot until the next cycle.
   assign w_alu_acc = wb.alu_valid && !w_full;

   assign wb.alu_ready   = !w_full;
   assign wb.mem_ready   = 1'b1;
   assign wb.write_index = r_write_index;
   assign wb.write_value = r_write_value;
   assign wb.busy        = r_busy;
   assign wb.sb_error    = r_sb_error;

   // Pick the write source; an ALU result that is not taken directly is queued.
   always_comb begin
      w_sel_index = '0;
      w_sel_value = '0;
      w_pop       = 1'b0;
      w_push      = 1'b0;
      if (wb.mem_valid) begin
         w_sel_index = wb.mem_index;
         w_sel_value = wb.mem_value;
         w_push      = w_alu_acc;
      end else if (!w_empty) begin
         w_sel_index = r_fifo_idx[r_rd_ptr[AW-1:0]];
         w_sel_value = r_fifo_val[r_rd_ptr[AW-1:0]];
         w_pop       = 1'b1;
         w_push      = w_alu_acc;
      end else if (w_alu_acc) begin
         w_sel_index = wb.alu_index;
         w_sel_value = wb.alu_value;
      end
   end

   // Scoreboard masks and protocol checks; a result for a register issued in
   // the same cycle is legal even though its busy bit is not yet set.
   always_comb begin
      w_set_mask  = wb.issue_valid ? (32'd1 << wb.issue_index) : 32'd0;
      w_clr_mask  = 32'd1 << r_write_index;
      w_issue_err = wb.issue_valid && (wb.issue_index != 5'd0) &&
                    r_busy[wb.issue_index];
      w_mem_err   = wb.mem_valid && (wb.mem_index != 5'd0) &&
                    !r_busy[wb.mem_index] &&
                    !(wb.issue_valid && (wb.issue_index == wb.mem_index));
      w_alu_err   = w_alu_acc && (wb.alu_index != 5'd0) &&
                    !r_busy[wb.alu_index] &&
                    !(wb.issue_valid && (wb.issue_index == wb.alu_index));
   end

   // FIFO payload storage; contents are meaningless while the pointers say empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_idx[r_wr_ptr[AW-1:0]] <= wb.alu_index;
         r_fifo_val[r_wr_ptr[AW-1:0]] <= wb.alu_value;
      end
   end

   // Control state: pointers, write register, scoreboard and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_write_index <= '0;
         r_write_value <= '0;
         r_busy        <= '0;
         r_sb_error    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_write_index <= w_sel_index;
         r_write_value <= w_sel_value;
         // A new issue wins over the clear of the register being written now.
         r_busy        <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
         if (w_issue_err || w_mem_err || w_alu_err) r_sb_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a queue-based model.
module tb_writeback_unit;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   writeback_unit_if #(.XLEN(XLEN)) wb ();

   writeback_unit #(.FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb.slave)
   );

   always #5 clk = ~clk;

   // Reference state: queue of waiting ALU results {index, value}.
   logic [36:0] m_q[$];
   logic [31:0] m_busy;
   logic [4:0]  m_widx;
   logic [31:0] m_wval;
   logic        m_err;
   logic [4:0]  pend[$];
   logic [4:0]  obs[$];

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_widx"}, wb.write_index, m_widx);
      chk({tag, "_wval"}, wb.write_value, m_wval);
      chk({tag, "_busy"}, wb.busy, m_busy);
      chk({tag, "_err"},  wb.sb_error, m_err);
   endtask

   function automatic logic stale(input logic [4:0] idx);
      return (idx != 5'd0) && !m_busy[idx] &&
             !(wb.issue_valid && (wb.issue_index == idx));
   endfunction

   function automatic bit in_pend(input logic [4:0] r);
      foreach (pend[i]) if (pend[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   // One clock of the architectural rules applied to the current inputs.
   task automatic model_step();
      logic        acc;
      logic        direct;
      logic [36:0] e;
      logic [4:0]  si;
      logic [31:0] sv;
      acc    = wb.alu_valid && (m_q.size() < DEPTH);
      direct = !wb.mem_valid && (m_q.size() == 0);
      if (wb.issue_valid && wb.issue_index != 5'd0 && m_busy[wb.issue_index]) m_err = 1'b1;
      if (wb.mem_valid && stale(wb.mem_index)) m_err = 1'b1;
      if (acc && stale(wb.alu_index)) m_err = 1'b1;
      si = '0;
      sv = '0;
      if (wb.mem_valid) begin
         si = wb.mem_index;
         sv = wb.mem_value;
      end else if (m_q.size() > 0) begin
         e  = m_q.pop_front();
         si = e[36:32];
         sv = e[31:0];
      end else if (acc) begin
         si = wb.alu_index;
         sv = wb.alu_value;
      end
      if (acc && !direct) m_q.push_back({wb.alu_index, wb.alu_value});
      m_busy[m_widx] = 1'b0;
      if (wb.issue_valid) m_busy[wb.issue_index] = 1'b1;
      m_busy[0] = 1'b0;
      m_widx = si;
      m_wval = sv;
   endtask

   task automatic idle();
      wb.issue_valid = 1'b0; wb.issue_index = '0;
      wb.alu_valid   = 1'b0; wb.alu_index   = '0; wb.alu_value = '0;
      wb.mem_valid   = 1'b0; wb.mem_index   = '0; wb.mem_value = '0;
   endtask

   task automatic cycle();
      chk("alu_ready", wb.alu_ready, (m_q.size() < DEPTH));
      model_step();
      @(posedge clk);
      #1;
      check_all("cyc");
   endtask

   // Asynchronous reset asserted mid-cycle, released just after an edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      idle();
      m_q.delete(); pend.delete();
      m_busy = '0; m_widx = '0; m_wval = '0; m_err = 1'b0;
      #1;
      check_all("rst");
      chk("rst_alu_ready", wb.alu_ready, 1'b1);
      chk("rst_mem_ready", wb.mem_ready, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [4:0] r);
      wb.issue_valid = 1'b1; wb.issue_index = r;
      cycle();
      wb.issue_valid = 1'b0; wb.issue_index = '0;
   endtask

   initial begin
      int a;
      idle();
      do_reset();

      // Single ALU result to a freshly issued register.
      issue(5'd5);
      wb.alu_valid = 1'b1; wb.alu_index = 5'd5; wb.alu_value = 32'h1234_5678;
      cycle();
      chk("t1_widx", wb.write_index, 5'd5);
      chk("t1_wval", wb.write_value, 32'h1234_5678);
      chk("t1_busy5_set", wb.busy[5], 1'b1);
      idle();
      cycle();
      chk("t1_busy5_clr", wb.busy[5], 1'b0);
      chk("t1_err", wb.sb_error, 1'b0);

      // Load and ALU collide: load first, ALU from the FIFO next cycle.
      issue(5'd3);
      issue(5'd4);
      wb.mem_valid = 1'b1; wb.mem_index = 5'd3; wb.mem_value = 32'hAAAA_0001;
      wb.alu_valid = 1'b1; wb.alu_index = 5'd4; wb.alu_value = 32'h0000_0BBB;
      cycle();
      chk("t2_widx3", wb.write_index, 5'd3);
      chk("t2_wval3", wb.write_value, 32'hAAAA_0001);
      idle();
      cycle();
      chk("t2_widx4", wb.write_index, 5'd4);
      chk("t2_wval4", wb.write_value, 32'h0000_0BBB);
      chk("t2_busy3_clr", wb.busy[3], 1'b0);
      chk("t2_busy4_set", wb.busy[4], 1'b1);
      cycle();
      chk("t2_busy4_clr", wb.busy[4], 1'b0);

      // Sustained loads fill the FIFO and back-pressure the ALU.
      do_reset();
      for (int r = 10; r < 22; r++) issue(5'(r));
      a = 0;
      for (int k = 0; k < 6; k++) begin
         bit acc_now;
         wb.mem_valid = 1'b1; wb.mem_index = 5'(10 + k); wb.mem_value = 32'hC000_0000 + k;
         wb.alu_valid = 1'b1; wb.alu_index = 5'(16 + a); wb.alu_value = 32'h100 + a;
         acc_now = wb.alu_ready;
         cycle();
         if (acc_now) a++;
      end
      chk("t3_accepts", a, 4);
      chk("t3_ready_low", wb.alu_ready, 1'b0);
      wb.mem_valid = 1'b0;
      obs.delete();
      for (int k = 0; k < 20; k++) begin
         bit acc_now;
         if (a < 6) begin
            wb.alu_valid = 1'b1; wb.alu_index = 5'(16 + a); wb.alu_value = 32'h100 + a;
         end else begin
            wb.alu_valid = 1'b0;
         end
         acc_now = wb.alu_valid && wb.alu_ready;
         cycle();
         if (acc_now) a++;
         if (wb.write_index >= 5'd16) obs.push_back(wb.write_index);
      end
      chk("t3_drain_cnt", obs.size(), 6);
      foreach (obs[i]) chk("t3_order", obs[i], 16 + i);
      chk("t3_busy_empty", wb.busy, 32'h0);

      // Double issue without a write raises a sticky error.
      do_reset();
      issue(5'd7);
      issue(5'd7);
      chk("t4_err_dbl", wb.sb_error, 1'b1);
      idle();
      for (int k = 0; k < 3; k++) cycle();
      chk("t4_err_sticky", wb.sb_error, 1'b1);
      do_reset();
      wb.alu_valid = 1'b1; wb.alu_index = 5'd9; wb.alu_value = 32'hDEAD_BEEF;
      cycle();
      chk("t4_err_stale", wb.sb_error, 1'b1);
      chk("t4_widx9", wb.write_index, 5'd9);

      // Index-0 result consumes the slot but writes nothing.
      do_reset();
      wb.alu_valid = 1'b1; wb.alu_index = 5'd0; wb.alu_value = 32'hFFFF_FFFF;
      cycle();
      chk("t5_widx", wb.write_index, 5'd0);
      chk("t5_wval", wb.write_value, 32'hFFFF_FFFF);
      chk("t5_busy", wb.busy, 32'h0);
      chk("t5_err", wb.sb_error, 1'b0);

      // Reset with three queued results and four busy registers.
      do_reset();
      for (int r = 4; r < 8; r++) issue(5'(r));
      for (int k = 0; k < 3; k++) begin
         wb.mem_valid = 1'b1; wb.mem_index = 5'd0; wb.mem_value = $urandom;
         wb.alu_valid = 1'b1; wb.alu_index = 5'(5 + k); wb.alu_value = $urandom;
         cycle();
      end
      chk("t6_busy_pre", wb.busy, 32'h0000_00F0);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("t6_no_write", wb.write_index, 5'd0);
      end

      // Randomized legal traffic: results only for issued registers.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] r;
         bit         acc_now;
         wb.issue_valid = 1'b0; wb.issue_index = '0;
         if ($urandom_range(0, 1) == 1) begin
            r = 5'($urandom_range(1, 31));
            if (!m_busy[r] && !in_pend(r)) begin
               wb.issue_valid = 1'b1; wb.issue_index = r;
            end
         end
         wb.mem_valid = 1'b0;
         if ($urandom_range(0, 3) == 0 && pend.size() > 0) begin
            wb.mem_valid = 1'b1; wb.mem_index = pend.pop_front(); wb.mem_value = $urandom;
         end else if ($urandom_range(0, 15) == 0) begin
            wb.mem_valid = 1'b1; wb.mem_index = 5'd0; wb.mem_value = $urandom;
         end
         if (!wb.alu_valid && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            wb.alu_valid = 1'b1; wb.alu_index = pend.pop_front(); wb.alu_value = $urandom;
         end
         acc_now = wb.alu_valid && wb.alu_ready;
         cycle();
         if (wb.issue_valid) pend.push_back(wb.issue_index);
         if (acc_now) wb.alu_valid = 1'b0;
         if (n % 100 == 99) do_reset();
      end

      // Unconstrained burst, protocol violations included.
      for (int n = 0; n < 60; n++) begin
         wb.issue_valid = 1'($urandom_range(0, 1)); wb.issue_index = 5'($urandom_range(0, 31));
         wb.alu_valid   = 1'($urandom_range(0, 1)); wb.alu_index   = 5'($urandom_range(0, 31));
         wb.alu_value   = $urandom;
         wb.mem_valid   = 1'($urandom_range(0, 1)); wb.mem_index   = 5'($urandom_range(0, 31));
         wb.mem_value   = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register-file write port: collects results from the ALU (single-cycle) and the load unit (multi-cycle) and drives one registered write per cycle into the 32x32 register file's write_index/write_value.
- Maintains a 32-entry busy scoreboard so decode can stall reads of pending destinations.
- Register file reads are combinational and writes land on the clock edge, so a cleared busy bit guarantees the register file already holds the value.

Parameters:
FIFO_DEPTH, 4, ALU-result holding FIFO entries; power of two, >= 2
XLEN, 32, data width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode issued an instruction with a destination this cycle
issue_index  input  5  destination register of issued instruction
alu_valid  input  1  ALU result valid
alu_index  input  5  ALU destination
alu_value  input  XLEN  ALU result
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready
mem_valid  input  1  load result valid
mem_index  input  5  load destination
mem_value  input  XLEN  load data
mem_ready  output  1  always 1 out of reset; load results are never back-pressured
write_index  output  5  to register file; 0 = no write
write_value  output  XLEN  to register file
busy  output  32  scoreboard, bit i = register i pending
sb_error  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, rst_n low), any cycle including mid-drain: write_index=0, write_value=0, busy=0, FIFO emptied (count 0), sb_error=0, alu_ready=1, mem_ready=1. In-flight results are discarded.
- Write register: each cycle exactly one source is selected. Priority: mem input > FIFO head > direct ALU input.
  - Selected index/value load into write_index/write_value at the next edge (E0).
  - If nothing is selected, write_index loads 0.
  - The register file captures the value at E1.
- ALU path:
  - Accepted ALU result goes direct to the write register only if mem_valid=0 and the FIFO is empty.
  - Otherwise it is pushed into the FIFO.
  - alu_ready = !fifo_full, using the registered FIFO state; a same-cycle pop does not raise it.
  - FIFO push and pop may occur in the same cycle: count is unchanged.
- Scoreboard:
  - issue_valid with index != 0 sets busy[index] at the next edge.
  - busy[write_index] clears at E1, the same edge the register file writes. After E1, busy is low and a combinational read returns the new value.
  - busy[0] is always 0. issue_index 0 is ignored.
- Index-0 results: accepted normally and consume a write slot; write_index=0 produces no register write and causes no busy change.
- Errors (sb_error sets at the next edge, clears only on reset):
  - issue_valid to an index whose busy bit is set, including the cycle its clear is pending at E1. Decode must stall on busy.
  - Accepted result with index != 0 whose busy bit is 0 and which is not set by a same-cycle issue.
  - The erroneous event is still processed (bit set / write performed).
- Latency: result accepted at edge E0 -> write_index/write_value valid during cycle E0..E1 -> register file and busy updated at E1. Minimum 2 edges, plus FIFO wait.
- FIFO wrap: read/write pointers wrap modulo FIFO_DEPTH; full/empty tracked with an extra pointer bit.

Test Plan:
- Reset then issue r5, ALU {r5, 0x1234_5678} one cycle later -> write_index=5, write_value=0x12345678 after 1 edge; busy[5] 1->0 at the following edge; sb_error=0.
- Same-cycle mem {r3, 0xAAAA_0001} and ALU {r4, 0x0000_0BBB} (both issued) -> r3 written first, r4 from FIFO next cycle; busy[3] and busy[4] clear on consecutive edges.
- mem_valid held high 6 cycles while the ALU offers 6 results (FIFO_DEPTH=4) -> alu_ready drops after 4 accepts; FIFO drains in order once mem goes idle; no result lost or duplicated.
- Issue r7 twice without a write -> sb_error=1 and stays 1; ALU result to non-busy r9 in a fresh run -> sb_error=1.
- ALU result to r0 with value 0xFFFF_FFFF -> write_index=0, busy unchanged, sb_error=0.
- rst_n asserted mid-sequence with 3 FIFO entries and busy=0x0000_00F0 -> all outputs return to reset values immediately; no writes after release.
